// File: rtl/redmule_job_ctrl.sv
// Multi-job tile-loop controller for the RedMulE datapath: queues job descriptors and
// sequences first-load, compute, Z-buffering and storing phases for each one in turn.
module redmule_job_ctrl #(
    parameter int unsigned HEIGHT = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned N_CTX  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [CNT_W-1:0]           job_w_rows_i,
    input  logic [CNT_W-1:0]           job_tot_stores_i,
    input  logic                       job_acc_init_i,
    input  logic                       w_loaded_i,
    input  logic                       reg_enable_i,
    input  logic                       zbuf_full_i,
    input  logic                       zbuf_empty_i,
    output logic                       busy_o,
    output logic                       first_load_o,
    output logic                       storing_o,
    output logic                       w_shift_o,
    output logic                       z_fill_o,
    output logic                       zbuf_clk_en_o,
    output logic                       accumulate_o,
    output logic                       flush_o,
    output logic                       done_o,
    output logic [$clog2(N_CTX+1)-1:0] pending_o
);

    localparam int unsigned PW = $clog2(N_CTX + 1);
    localparam int unsigned AW = (N_CTX > 1) ? $clog2(N_CTX) : 1;
    localparam int unsigned HW = $clog2(HEIGHT);

    typedef enum logic [2:0] {
        IDLE, STARTING, COMPUTING, BUFFERING, STORING, FINISHED
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  q_rows_q   [N_CTX];
    logic [CNT_W-1:0]  q_rows_d   [N_CTX];
    logic [CNT_W-1:0]  q_stores_q [N_CTX];
    logic [CNT_W-1:0]  q_stores_d [N_CTX];
    logic [N_CTX-1:0]  q_acc_q, q_acc_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  act_rows_q, act_rows_d, act_stores_q, act_stores_d;
    logic              act_acc_q, act_acc_d;
    logic [CNT_W-1:0]  w_row_cnt_q, w_row_cnt_d, store_cnt_q, store_cnt_d;
    logic [HW-1:0]     pe_cnt_q, pe_cnt_d;
    logic              arm_q, arm_d;
    logic              accumulate_q, accumulate_d, acc_prev_q, acc_prev_d;

    logic              full, push, pop, hd_degen, w_inc;
    logic [CNT_W-1:0]  arm_thr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(N_CTX - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        q_rows_d     = q_rows_q;
        q_stores_d   = q_stores_q;
        q_acc_d      = q_acc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        act_rows_d   = act_rows_q;
        act_stores_d = act_stores_q;
        act_acc_d    = act_acc_q;
        w_row_cnt_d  = w_row_cnt_q;
        store_cnt_d  = store_cnt_q;
        pe_cnt_d     = pe_cnt_q;
        arm_d        = arm_q;
        accumulate_d = accumulate_q;
        acc_prev_d   = accumulate_q;

        busy_o        = 1'b0;
        first_load_o  = 1'b0;
        storing_o     = 1'b0;
        w_shift_o     = 1'b0;
        z_fill_o      = 1'b0;
        zbuf_clk_en_o = 1'b0;
        flush_o       = 1'b0;
        done_o        = 1'b0;

        full        = (cnt_q == PW'(N_CTX));
        job_ready_o = !full && !clear_i;
        push        = job_valid_i && job_ready_o;
        pop         = !clear_i && (cnt_q != '0) && (state_q == IDLE || state_q == FINISHED);
        hd_degen    = (q_rows_q[rd_ptr_q] == '0) || (q_stores_q[rd_ptr_q] == '0);
        w_inc       = w_loaded_i && (w_row_cnt_q != act_rows_q);
        arm_thr     = (act_rows_q < CNT_W'(HEIGHT)) ? act_rows_q : CNT_W'(HEIGHT);

        if (push) begin
            q_rows_d[wr_ptr_q]   = job_w_rows_i;
            q_stores_d[wr_ptr_q] = job_tot_stores_i;
            q_acc_d[wr_ptr_q]    = job_acc_init_i;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end

        unique case (state_q)
            IDLE: ;
            STARTING: begin
                busy_o       = 1'b1;
                first_load_o = 1'b1;
                if (w_loaded_i) begin
                    w_row_cnt_d  = CNT_W'(1);
                    accumulate_d = act_acc_q;
                    state_d      = COMPUTING;
                end
            end
            COMPUTING: begin
                busy_o    = 1'b1;
                w_shift_o = 1'b1;
                if (w_inc) w_row_cnt_d = w_row_cnt_q + 1'b1;
                if (w_row_cnt_q >= arm_thr) arm_d = 1'b1;
                // pe_cnt wraps once per weight tile; a tile ending on the last row closes the pass
                if (arm_q && reg_enable_i) begin
                    if (pe_cnt_q == HW'(HEIGHT - 1)) begin
                        pe_cnt_d     = '0;
                        accumulate_d = 1'b1;
                        if (w_row_cnt_q == act_rows_q) begin
                            state_d      = BUFFERING;
                            arm_d        = 1'b0;
                            accumulate_d = act_acc_q;
                            w_row_cnt_d  = CNT_W'(w_loaded_i);
                        end
                    end else begin
                        pe_cnt_d = pe_cnt_q + 1'b1;
                    end
                end
            end
            BUFFERING: begin
                busy_o        = 1'b1;
                zbuf_clk_en_o = 1'b1;
                z_fill_o      = reg_enable_i;
                if (w_inc) w_row_cnt_d = w_row_cnt_q + 1'b1;
                if (zbuf_full_i) state_d = STORING;
            end
            STORING: begin
                busy_o    = 1'b1;
                storing_o = 1'b1;
                if (w_inc) w_row_cnt_d = w_row_cnt_q + 1'b1;
                if (zbuf_empty_i) begin
                    store_cnt_d = store_cnt_q + 1'b1;
                    state_d     = (store_cnt_q == act_stores_q - 1'b1) ? FINISHED : COMPUTING;
                end
            end
            FINISHED: begin
                done_o       = !clear_i;
                flush_o      = 1'b1;
                w_row_cnt_d  = '0;
                store_cnt_d  = '0;
                pe_cnt_d     = '0;
                arm_d        = 1'b0;
                accumulate_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            act_rows_d   = q_rows_q[rd_ptr_q];
            act_stores_d = q_stores_q[rd_ptr_q];
            act_acc_d    = q_acc_q[rd_ptr_q];
            rd_ptr_d     = ptr_inc(rd_ptr_q);
            state_d      = hd_degen ? FINISHED : STARTING;
        end

        if (clear_i) begin
            state_d      = IDLE;
            cnt_d        = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            act_rows_d   = '0;
            act_stores_d = '0;
            act_acc_d    = 1'b0;
            w_row_cnt_d  = '0;
            store_cnt_d  = '0;
            pe_cnt_d     = '0;
            arm_d        = 1'b0;
            accumulate_d = 1'b0;
            acc_prev_d   = 1'b0;
        end

        // a freshly raised accumulate waits for the pipeline to advance once before it is seen
        accumulate_o = accumulate_q && (reg_enable_i || acc_prev_q);
        pending_o    = cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < N_CTX; i++) begin
                q_rows_q[i]   <= '0;
                q_stores_q[i] <= '0;
            end
            q_acc_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            act_rows_q   <= '0;
            act_stores_q <= '0;
            act_acc_q    <= 1'b0;
            w_row_cnt_q  <= '0;
            store_cnt_q  <= '0;
            pe_cnt_q     <= '0;
            arm_q        <= 1'b0;
            accumulate_q <= 1'b0;
            acc_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_rows_q     <= q_rows_d;
            q_stores_q   <= q_stores_d;
            q_acc_q      <= q_acc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            act_rows_q   <= act_rows_d;
            act_stores_q <= act_stores_d;
            act_acc_q    <= act_acc_d;
            w_row_cnt_q  <= w_row_cnt_d;
            store_cnt_q  <= store_cnt_d;
            pe_cnt_q     <= pe_cnt_d;
            arm_q        <= arm_d;
            accumulate_q <= accumulate_d;
            acc_prev_q   <= acc_prev_d;
        end
    end

endmodule

// File: tb/tb_redmule_job_ctrl.sv
// Directed bench for redmule_job_ctrl: single jobs, queueing order, degenerate jobs,
// soft clear and asynchronous reset, all against hand-computed cycle numbers.
module tb_redmule_job_ctrl;

    localparam int unsigned HEIGHT = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned N_CTX  = 2;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clear_i = 1'b0;
    logic             job_valid_i = 1'b0;
    logic             job_ready_o;
    logic [CNT_W-1:0] job_w_rows_i = '0;
    logic [CNT_W-1:0] job_tot_stores_i = '0;
    logic             job_acc_init_i = 1'b0;
    logic             w_loaded_i = 1'b0;
    logic             reg_enable_i = 1'b1;
    logic             zbuf_full_i = 1'b1;
    logic             zbuf_empty_i = 1'b1;
    logic             busy_o, first_load_o, storing_o, w_shift_o, z_fill_o;
    logic             zbuf_clk_en_o, accumulate_o, flush_o, done_o;
    logic [1:0]       pending_o;

    int n_cmp = 0;
    int n_err = 0;

    // per-run statistics
    int   st_fl, st_shift, st_buf, st_fill, st_store, st_acc, st_busy, st_done, st_flush, done_at;
    logic acc_at [64];

    always #5 clk_i = ~clk_i;

    redmule_job_ctrl #(.HEIGHT(HEIGHT), .CNT_W(CNT_W), .N_CTX(N_CTX)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .job_valid_i      (job_valid_i),
        .job_ready_o      (job_ready_o),
        .job_w_rows_i     (job_w_rows_i),
        .job_tot_stores_i (job_tot_stores_i),
        .job_acc_init_i   (job_acc_init_i),
        .w_loaded_i       (w_loaded_i),
        .reg_enable_i     (reg_enable_i),
        .zbuf_full_i      (zbuf_full_i),
        .zbuf_empty_i     (zbuf_empty_i),
        .busy_o           (busy_o),
        .first_load_o     (first_load_o),
        .storing_o        (storing_o),
        .w_shift_o        (w_shift_o),
        .z_fill_o         (z_fill_o),
        .zbuf_clk_en_o    (zbuf_clk_en_o),
        .accumulate_o     (accumulate_o),
        .flush_o          (flush_o),
        .done_o           (done_o),
        .pending_o        (pending_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [8:0] outs_vec();
        return {busy_o, first_load_o, storing_o, w_shift_o, z_fill_o,
                zbuf_clk_en_o, accumulate_o, flush_o, done_o};
    endfunction

    task automatic set_job(input int rows, input int stores, input logic acc);
        job_w_rows_i     = CNT_W'(rows);
        job_tot_stores_i = CNT_W'(stores);
        job_acc_init_i   = acc;
    endtask

    // one job pushed at step 0, w_loaded_i on odd steps from 3, zbuf flags held high
    task automatic run_single(input int rows, input int stores, input logic acc,
                              input int re_lo, input int re_hi);
        st_fl = 0; st_shift = 0; st_buf = 0; st_fill = 0; st_store = 0;
        st_acc = 0; st_busy = 0; st_done = 0; st_flush = 0; done_at = 999;
        set_job(rows, stores, acc);
        zbuf_full_i  = 1'b1;
        zbuf_empty_i = 1'b1;
        for (int s = 0; s < 45; s++) begin
            nxt();
            job_valid_i  = (s == 0);
            w_loaded_i   = (s >= 3) && (s % 2 == 1);
            reg_enable_i = !(s == re_lo || s == re_hi);
            #1;
            if (first_load_o)  st_fl++;
            if (w_shift_o)     st_shift++;
            if (zbuf_clk_en_o) st_buf++;
            if (z_fill_o)      st_fill++;
            if (storing_o)     st_store++;
            if (accumulate_o)  st_acc++;
            if (busy_o)        st_busy++;
            if (flush_o)       st_flush++;
            if (done_o) begin
                st_done++;
                if (done_at == 999) done_at = s;
            end
            acc_at[s] = accumulate_o;
        end
        job_valid_i  = 1'b0;
        w_loaded_i   = 1'b0;
        reg_enable_i = 1'b1;
    endtask

    int   done_s   [4];
    int   done_st  [4];
    int   nd, sc, d_push_at, fl_after, dn_cnt;
    logic d_wait;

    initial begin
        // ---------------- reset state
        #12;
        chk("rst_outs", 32'(outs_vec()), 0);
        chk("rst_ready", 32'(job_ready_o), 1);
        chk("rst_pending", 32'(pending_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        nxt();
        chk("idle_outs", 32'(outs_vec()), 0);

        // ---------------- w_rows=8, tot_stores=2, acc_init=0
        run_single(8, 2, 1'b0, 99, 99);
        chk("t1_first_load_cycles", 32'(st_fl), 2);
        chk("t1_w_shift_cycles", 32'(st_shift), 29);
        chk("t1_buffering_cycles", 32'(st_buf), 2);
        chk("t1_z_fill_cycles", 32'(st_fill), 2);
        chk("t1_storing_cycles", 32'(st_store), 2);
        chk("t1_busy_cycles", 32'(st_busy), 35);
        chk("t1_done_count", 32'(st_done), 1);
        chk("t1_flush_count", 32'(st_flush), 1);
        chk("t1_done_step", 32'(done_at), 37);
        chk("t1_acc_cycles", 32'(st_acc), 8);
        chk("t1_acc_first_compute", 32'(acc_at[4]), 0);
        chk("t1_acc_before_tile", 32'(acc_at[14]), 0);
        chk("t1_acc_after_tile", 32'(acc_at[15]), 1);
        chk("t1_acc_pass2_start", 32'(acc_at[21]), 0);

        // ---------------- acc_init=1, reg_enable_i low on the first two compute cycles
        run_single(8, 2, 1'b1, 4, 5);
        chk("t2_acc_gated", 32'(acc_at[4]), 0);
        chk("t2_acc_held", 32'(acc_at[5]), 1);
        chk("t2_acc_mid", 32'(acc_at[12]), 1);
        chk("t2_acc_pass2_start", 32'(acc_at[21]), 1);
        chk("t2_done_step", 32'(done_at), 37);
        chk("t2_z_fill_cycles", 32'(st_fill), 2);

        // ---------------- degenerate jobs
        run_single(0, 3, 1'b0, 99, 99);
        chk("t3_rows0_first_load", 32'(st_fl), 0);
        chk("t3_rows0_busy", 32'(st_busy), 0);
        chk("t3_rows0_done_count", 32'(st_done), 1);
        chk("t3_rows0_done_step", 32'(done_at), 2);
        run_single(5, 0, 1'b0, 99, 99);
        chk("t3_st0_first_load", 32'(st_fl), 0);
        chk("t3_st0_done_step", 32'(done_at), 2);

        // ---------------- queue: A(1 store) running, B(2) and C(3) pushed, D(1) stalls
        w_loaded_i = 1'b1; reg_enable_i = 1'b1; zbuf_full_i = 1'b1; zbuf_empty_i = 1'b1;
        nd = 0; sc = 0; d_push_at = 999; d_wait = 1'b1;
        for (int s = 0; s < 66; s++) begin
            nxt();
            job_valid_i = 1'b0;
            if (s == 0) begin set_job(1, 1, 1'b0); job_valid_i = 1'b1; end
            if (s == 2) begin set_job(1, 2, 1'b0); job_valid_i = 1'b1; end
            if (s == 3) begin set_job(1, 3, 1'b0); job_valid_i = 1'b1; end
            if (s >= 4 && d_wait) begin set_job(1, 1, 1'b0); job_valid_i = 1'b1; end
            #1;
            if (s >= 4 && d_wait && job_ready_o) begin
                d_wait = 1'b0;
                d_push_at = s;
            end
            if (storing_o) sc++;
            if (done_o) begin
                if (nd < 4) begin
                    done_s[nd]  = s;
                    done_st[nd] = sc;
                end
                nd++;
                sc = 0;
            end
            if (s == 1)  chk("q_pending_s1", 32'(pending_o), 1);
            if (s == 2)  chk("q_pending_s2", 32'(pending_o), 0);
            if (s == 3)  chk("q_pending_s3", 32'(pending_o), 1);
            if (s == 4)  chk("q_pending_s4", 32'(pending_o), 2);
            if (s == 4)  chk("q_ready_full", 32'(job_ready_o), 0);
            if (s == 10) chk("q_ready_pop_cycle", 32'(job_ready_o), 0);
            if (s == 10) chk("q_pending_pop_cycle", 32'(pending_o), 2);
            if (s == 11) chk("q_pending_s11", 32'(pending_o), 1);
            if (s == 12) chk("q_pending_s12", 32'(pending_o), 2);
            if (s == 27) chk("q_pending_s27", 32'(pending_o), 1);
            if (s == 50) chk("q_pending_s50", 32'(pending_o), 0);
        end
        job_valid_i = 1'b0;
        chk("q_d_push_step", 32'(d_push_at), 11);
        chk("q_done_count", 32'(nd), 4);
        if (nd >= 4) begin
            chk("q_done_a_step", 32'(done_s[0]), 10);
            chk("q_done_b_step", 32'(done_s[1]), 26);
            chk("q_done_c_step", 32'(done_s[2]), 49);
            chk("q_done_d_step", 32'(done_s[3]), 58);
            chk("q_stores_a", 32'(done_st[0]), 1);
            chk("q_stores_b", 32'(done_st[1]), 2);
            chk("q_stores_c", 32'(done_st[2]), 3);
            chk("q_stores_d", 32'(done_st[3]), 1);
        end

        // ---------------- clear_i while STORING with one job queued
        zbuf_empty_i = 1'b0;
        dn_cnt = 0; fl_after = 0;
        for (int s = 0; s < 20; s++) begin
            nxt();
            job_valid_i = 1'b0;
            clear_i     = (s == 10);
            if (s == 0) begin set_job(1, 2, 1'b0); job_valid_i = 1'b1; end
            if (s == 2) begin set_job(1, 1, 1'b0); job_valid_i = 1'b1; end
            #1;
            if (done_o) dn_cnt++;
            if (s >= 11 && first_load_o) fl_after++;
            if (s == 9)  chk("clr_storing_before", 32'(storing_o), 1);
            if (s == 10) chk("clr_pending_before", 32'(pending_o), 1);
            if (s == 10) chk("clr_ready_during", 32'(job_ready_o), 0);
            if (s == 11) begin
                chk("clr_busy_after", 32'(busy_o), 0);
                chk("clr_pending_after", 32'(pending_o), 0);
                chk("clr_ready_after", 32'(job_ready_o), 1);
                chk("clr_outs_after", 32'(outs_vec()), 0);
            end
        end
        chk("clr_no_done", 32'(dn_cnt), 0);
        chk("clr_queue_flushed", 32'(fl_after), 0);
        clear_i = 1'b0;
        zbuf_empty_i = 1'b1;

        // ---------------- asynchronous reset mid-COMPUTING
        for (int s = 0; s < 5; s++) begin
            nxt();
            job_valid_i = 1'b0;
            if (s == 0) begin set_job(8, 2, 1'b1); job_valid_i = 1'b1; end
            if (s == 2) begin set_job(1, 1, 1'b0); job_valid_i = 1'b1; end
            #1;
        end
        chk("ar_in_compute", 32'(w_shift_o), 1);
        chk("ar_pending_before", 32'(pending_o), 1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("ar_outs", 32'(outs_vec()), 0);
        chk("ar_ready", 32'(job_ready_o), 1);
        chk("ar_pending", 32'(pending_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_single(0, 1, 1'b0, 99, 99);
        chk("ar_post_done_step", 32'(done_at), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
